// File: rtl/worley_point_animator_if.sv
// Handshake bundle between the frame-timing logic and the point animator.
// The animator takes the slave side; the timing/consumer side takes the master side.
interface worley_point_animator_if #(
  parameter int unsigned NPTS = 4,
  parameter int unsigned XW   = 10,
  parameter int unsigned YW   = 10
);
  logic                 frame_tick;
  logic                 freeze;
  logic [NPTS*XW-1:0]   pts_x;
  logic [NPTS*YW-1:0]   pts_y;
  logic                 pts_valid;
  logic                 busy;
  logic                 overrun;
  logic [19:0]          frame_cnt;

  modport master (
    output frame_tick, freeze,
    input  pts_x, pts_y, pts_valid, busy, overrun, frame_cnt
  );

  modport slave (
    input  frame_tick, freeze,
    output pts_x, pts_y, pts_valid, busy, overrun, frame_cnt
  );
endinterface

// File: rtl/worley_point_animator.sv
// Worley feature-point animator: once per frame, moves every point by its velocity,
// bouncing off the screen edges, in a shadow copy. The shadow is then committed to
// the outputs in a single cycle so the noise stage never sees a half-updated set.
module worley_point_animator #(
  parameter int unsigned NPTS  = 4,
  parameter int unsigned XW    = 10,
  parameter int unsigned YW    = 10,
  parameter int          X_MAX = 639,
  parameter int          Y_MAX = 479,
  parameter int unsigned SPD_W = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  worley_point_animator_if.slave    bus_io
);

  localparam int unsigned IdxW = (NPTS > 1) ? $clog2(NPTS) : 1;
  localparam int unsigned XSW  = XW + 2;
  localparam int unsigned YSW  = YW + 2;
  localparam int unsigned VW   = SPD_W + 1;

  localparam logic signed [XSW-1:0] XMaxS   = XSW'(X_MAX);
  localparam logic signed [YSW-1:0] YMaxS   = YSW'(Y_MAX);
  localparam logic [IdxW-1:0]       LastIdx = IdxW'(NPTS - 1);
  localparam logic [15:0]           LfsrSeed = 16'hACE1;
  // Galois mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
  localparam logic [15:0]           LfsrMask = 16'hB400;

  typedef enum logic [1:0] {StIdle, StStep, StCommit} state_e;

  function automatic logic [XW-1:0] rst_x(int unsigned i);
    case (i)
      0:       return XW'(100);
      1:       return XW'(300);
      2:       return XW'(500);
      3:       return XW'(100);
      default: return XW'(80 * i);
    endcase
  endfunction

  function automatic logic [YW-1:0] rst_y(int unsigned i);
    case (i)
      0:       return YW'(100);
      1:       return YW'(200);
      2:       return YW'(400);
      3:       return YW'(379);
      default: return YW'(60 * i);
    endcase
  endfunction

  function automatic logic signed [VW-1:0] rst_vx(int unsigned i);
    return ((i % 4) == 0 || (i % 4) == 2) ? VW'(1) : VW'(-1);
  endfunction

  function automatic logic signed [VW-1:0] rst_vy(int unsigned i);
    return ((i % 4) == 1) ? VW'(1) : VW'(-1);
  endfunction

  // Bounce: new magnitude from the LFSR, sign opposite to the old one.
  function automatic logic signed [VW-1:0] bounce_v(logic signed [VW-1:0] v,
                                                     logic [SPD_W-1:0] m);
    logic signed [VW-1:0] mv;
    mv = $signed({1'b0, m});
    return (v > 0) ? -mv : mv;
  endfunction

  state_e                  state_q;
  logic [IdxW-1:0]         idx_q;
  logic [15:0]             lfsr_q;
  logic [XW-1:0]           sx_q  [NPTS];
  logic [YW-1:0]           sy_q  [NPTS];
  logic signed [VW-1:0]    vx_q  [NPTS];
  logic signed [VW-1:0]    vy_q  [NPTS];
  logic [NPTS*XW-1:0]      pts_x_q;
  logic [NPTS*YW-1:0]      pts_y_q;
  logic                    pts_valid_q;
  logic                    busy_q;
  logic                    overrun_q;
  logic [19:0]             frame_cnt_q;

  logic [XW-1:0]           cur_x, new_x;
  logic [YW-1:0]           cur_y, new_y;
  logic signed [VW-1:0]    cur_vx, cur_vy, new_vx, new_vy;
  logic signed [XSW-1:0]   nx;
  logic signed [YSW-1:0]   ny;
  logic [SPD_W-1:0]        mag;
  logic [15:0]             lfsr_nxt;
  logic                    tick_ok;

  assign tick_ok = bus_io.frame_tick && !bus_io.freeze;

  // Next position/velocity of the point selected by idx_q, and the next LFSR state.
  // Both axes of one point share the same LFSR value.
  always_comb begin
    cur_x  = sx_q[idx_q];
    cur_y  = sy_q[idx_q];
    cur_vx = vx_q[idx_q];
    cur_vy = vy_q[idx_q];
    mag    = lfsr_q[SPD_W-1:0];
    if (mag == '0) mag = SPD_W'(1);

    nx     = $signed({2'b00, cur_x}) + XSW'(cur_vx);
    new_vx = cur_vx;
    if (nx[XSW-1]) begin
      new_x  = XW'(-nx);
      new_vx = bounce_v(cur_vx, mag);
    end else if (nx > XMaxS) begin
      new_x  = XW'((XMaxS <<< 1) - nx);
      new_vx = bounce_v(cur_vx, mag);
    end else begin
      new_x  = XW'(nx);
    end

    ny     = $signed({2'b00, cur_y}) + YSW'(cur_vy);
    new_vy = cur_vy;
    if (ny[YSW-1]) begin
      new_y  = YW'(-ny);
      new_vy = bounce_v(cur_vy, mag);
    end else if (ny > YMaxS) begin
      new_y  = YW'((YMaxS <<< 1) - ny);
      new_vy = bounce_v(cur_vy, mag);
    end else begin
      new_y  = YW'(ny);
    end

    lfsr_nxt = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LfsrMask : 16'h0000);
  end

  // Update FSM with registered outputs; reset aborts any update in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      lfsr_q      <= LfsrSeed;
      pts_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      frame_cnt_q <= '0;
      for (int i = 0; i < int'(NPTS); i++) begin
        sx_q[i]                <= rst_x(i);
        sy_q[i]                <= rst_y(i);
        vx_q[i]                <= rst_vx(i);
        vy_q[i]                <= rst_vy(i);
        pts_x_q[i*XW +: XW]    <= rst_x(i);
        pts_y_q[i*YW +: YW]    <= rst_y(i);
      end
    end else begin
      pts_valid_q <= 1'b0;
      if (tick_ok && busy_q) overrun_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (tick_ok) begin
            state_q <= StStep;
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        StStep: begin
          sx_q[idx_q] <= new_x;
          sy_q[idx_q] <= new_y;
          vx_q[idx_q] <= new_vx;
          vy_q[idx_q] <= new_vy;
          lfsr_q      <= lfsr_nxt;
          if (idx_q == LastIdx) begin
            state_q <= StCommit;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        StCommit: begin
          for (int i = 0; i < int'(NPTS); i++) begin
            pts_x_q[i*XW +: XW] <= sx_q[i];
            pts_y_q[i*YW +: YW] <= sy_q[i];
          end
          pts_valid_q <= 1'b1;
          frame_cnt_q <= frame_cnt_q + 20'd1;
          busy_q      <= 1'b0;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus_io.pts_x     = pts_x_q;
  assign bus_io.pts_y     = pts_y_q;
  assign bus_io.pts_valid = pts_valid_q;
  assign bus_io.busy      = busy_q;
  assign bus_io.overrun   = overrun_q;
  assign bus_io.frame_cnt = frame_cnt_q;

endmodule
